// File: rtl/axi_llc_cfg_seq_pkg.sv
// -----------------------------------------------------------------------------
// axi_llc_cfg_seq_pkg
// Shared types, default register map offsets and small helpers for the LLC
// RegBus configuration sequencer.
//   cfg_op_e         : maintenance command opcode (FLUSH / SET_SPM)
//   cfg_seq_state_e  : sequencer FSM states
//   Def*             : default register file base / offsets
//   cfg_reg_addr()   : target register address of the configuration write
//   ways_flushed()   : status-poll completion test
// -----------------------------------------------------------------------------
package axi_llc_cfg_seq_pkg;

  typedef enum logic {
    CFG_FLUSH   = 1'b0,
    CFG_SET_SPM = 1'b1
  } cfg_op_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WR_CFG    = 3'd1,
    ST_WR_COMMIT = 3'd2,
    ST_POLL_RD   = 3'd3,
    ST_POLL_WAIT = 3'd4,
    ST_DONE      = 3'd5
  } cfg_seq_state_e;

  localparam logic [31:0] DefRegBaseAddr    = 32'h0000_0000;
  localparam logic [31:0] DefCfgSpmOffset   = 32'h0000_0000;
  localparam logic [31:0] DefCfgFlushOffset = 32'h0000_0008;
  localparam logic [31:0] DefCommitOffset   = 32'h0000_0010;
  localparam logic [31:0] DefFlushedOffset  = 32'h0000_0018;

  localparam logic [31:0] CommitValue = 32'h0000_0001;
  localparam logic [3:0]  WstrbFull   = 4'hF;
  localparam logic [3:0]  WstrbNone   = 4'h0;

  // Register that receives the way mask: SPM mask for SET_SPM, flush mask otherwise.
  function automatic logic [31:0] cfg_reg_addr(input cfg_op_e     op,
                                               input logic [31:0] base,
                                               input logic [31:0] spm_off,
                                               input logic [31:0] flush_off);
    logic [31:0] addr;
    if (op == CFG_SET_SPM) begin
      addr = base + spm_off;
    end else begin
      addr = base + flush_off;
    end
    return addr;
  endfunction

  // All requested ways are reported in the flushed-status word.
  function automatic logic ways_flushed(input logic [31:0] rdata,
                                        input logic [31:0] mask);
    return ((rdata & mask) == mask);
  endfunction

endpackage

// File: rtl/axi_llc_cfg_seq_timer.sv
// -----------------------------------------------------------------------------
// axi_llc_cfg_seq_timer
// Loadable down-counter that spaces out status polls.
//   clk_i, rst_ni : clock / asynchronous active-low reset
//   load_i        : load load_val_i this cycle (counting starts next cycle)
//   load_val_i    : interval length in cycles (>= 1)
//   expired_o     : current cycle is the last cycle of the interval
// After a load of N the flag rises in the N-th cycle following the load, so a
// caller that leaves its wait state on expired_o waits exactly N cycles.
// -----------------------------------------------------------------------------
module axi_llc_cfg_seq_timer
  import axi_llc_cfg_seq_pkg::*;
#(
  parameter int unsigned Width = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             expired_o
);

  localparam logic [Width-1:0] OneC = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  // Load or count down, holding at zero so the counter never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - OneC;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q <= OneC);

endmodule

// File: rtl/axi_llc_cfg_seq.sv
// -----------------------------------------------------------------------------
// axi_llc_cfg_seq
// RegBus configuration sequencer for the AXI LLC register wrapper. Turns a
// maintenance command (FLUSH a way set, or SET_SPM repartition) into the
// write-mask / write-commit / poll-status sequence on the LLC config port and
// reports a single completion pulse with an error flag.
//   cmd_valid_i/cmd_ready_o/cmd_op_i/cmd_mask_i : command handshake
//   done_o/done_error_o                          : completion pulse + error
//   busy_o                                       : command in flight
//   conf_req_*_o                                 : RegBus request (registered)
//   conf_resp_*_i                                : RegBus response
// -----------------------------------------------------------------------------
module axi_llc_cfg_seq
  import axi_llc_cfg_seq_pkg::*;
#(
  parameter int unsigned SetAssociativity = 8,
  parameter logic [31:0] RegBaseAddr      = DefRegBaseAddr,
  parameter logic [31:0] CfgSpmOffset     = DefCfgSpmOffset,
  parameter logic [31:0] CfgFlushOffset   = DefCfgFlushOffset,
  parameter logic [31:0] CommitOffset     = DefCommitOffset,
  parameter logic [31:0] FlushedOffset    = DefFlushedOffset,
  parameter int unsigned PollInterval     = 16,
  parameter int unsigned MaxPolls         = 1024
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_op_i,
  input  logic [SetAssociativity-1:0] cmd_mask_i,
  output logic                        done_o,
  output logic                        done_error_o,
  output logic                        busy_o,
  output logic [31:0]                 conf_req_addr_o,
  output logic                        conf_req_w_o,
  output logic [31:0]                 conf_req_wdata_o,
  output logic [3:0]                  conf_req_wstrb_o,
  output logic                        conf_req_valid_o,
  input  logic [31:0]                 conf_resp_rdata_i,
  input  logic                        conf_resp_error_i,
  input  logic                        conf_resp_ready_i
);

  localparam int unsigned PollCntW = $clog2(MaxPolls + 1);
  localparam int unsigned TimerW   = $clog2(PollInterval + 1);

  localparam logic [PollCntW-1:0] MaxPollsC     = PollCntW'(MaxPolls);
  localparam logic [PollCntW-1:0] PollOneC      = PollCntW'(1);
  localparam logic [TimerW-1:0]   PollIntervalC = TimerW'(PollInterval);

  localparam logic [31:0] CommitAddr  = RegBaseAddr + CommitOffset;
  localparam logic [31:0] FlushedAddr = RegBaseAddr + FlushedOffset;

  cfg_seq_state_e      state_q, state_d;
  cfg_op_e             op_q, op_d;
  logic [31:0]         mask_q, mask_d;
  logic [PollCntW-1:0] poll_cnt_q, poll_cnt_d;
  logic                req_valid_q, req_valid_d;
  logic [31:0]         req_addr_q, req_addr_d;
  logic                req_w_q, req_w_d;
  logic [31:0]         req_wdata_q, req_wdata_d;
  logic [3:0]          req_wstrb_q, req_wstrb_d;
  logic                done_q, done_d;
  logic                done_err_q, done_err_d;
  logic                busy_q, busy_d;
  logic                cmd_ready_q, cmd_ready_d;

  cfg_op_e     cmd_op_s;
  logic [31:0] cmd_mask_ext_s;
  logic        cmd_accept_s;
  logic        xfer_done_s;
  logic        timer_load_s;
  logic        timer_expired_s;

  assign cmd_op_s       = cfg_op_e'(cmd_op_i);
  assign cmd_mask_ext_s = 32'(cmd_mask_i);
  assign cmd_accept_s   = cmd_valid_i & cmd_ready_q;
  // A transfer completes only while our registered valid is up.
  assign xfer_done_s    = req_valid_q & conf_resp_ready_i;

  axi_llc_cfg_seq_timer #(
    .Width (TimerW)
  ) u_poll_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (timer_load_s),
    .load_val_i (PollIntervalC),
    .expired_o  (timer_expired_s)
  );

  // Sequencer next state, RegBus request fields and completion status.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    mask_d       = mask_q;
    poll_cnt_d   = poll_cnt_q;
    req_valid_d  = req_valid_q;
    req_addr_d   = req_addr_q;
    req_w_d      = req_w_q;
    req_wdata_d  = req_wdata_q;
    req_wstrb_d  = req_wstrb_q;
    done_d       = 1'b0;
    done_err_d   = 1'b0;
    timer_load_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_accept_s) begin
          op_d   = cmd_op_s;
          mask_d = cmd_mask_ext_s;
          if ((cmd_op_s == CFG_FLUSH) && (cmd_mask_ext_s == 32'h0000_0000)) begin
            // Nothing to flush: finish without touching the bus.
            state_d    = ST_DONE;
            done_d     = 1'b1;
            done_err_d = 1'b0;
          end else begin
            state_d     = ST_WR_CFG;
            req_valid_d = 1'b1;
            req_addr_d  = cfg_reg_addr(cmd_op_s, RegBaseAddr, CfgSpmOffset, CfgFlushOffset);
            req_w_d     = 1'b1;
            req_wdata_d = cmd_mask_ext_s;
            req_wstrb_d = WstrbFull;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_WR_CFG: begin
        if (xfer_done_s && conf_resp_error_i) begin
          state_d     = ST_DONE;
          req_valid_d = 1'b0;
          done_d      = 1'b1;
          done_err_d  = 1'b1;
        end else if (xfer_done_s) begin
          // Back-to-back: valid stays high, fields switch to the commit write.
          state_d     = ST_WR_COMMIT;
          req_valid_d = 1'b1;
          req_addr_d  = CommitAddr;
          req_w_d     = 1'b1;
          req_wdata_d = CommitValue;
          req_wstrb_d = WstrbFull;
        end else begin
          // Stalled: keep presenting the write derived from the latched command.
          req_addr_d  = cfg_reg_addr(op_q, RegBaseAddr, CfgSpmOffset, CfgFlushOffset);
          req_wdata_d = mask_q;
        end
      end

      ST_WR_COMMIT: begin
        if (xfer_done_s && conf_resp_error_i) begin
          state_d     = ST_DONE;
          req_valid_d = 1'b0;
          done_d      = 1'b1;
          done_err_d  = 1'b1;
        end else if (xfer_done_s) begin
          state_d     = ST_POLL_RD;
          poll_cnt_d  = '0;
          req_valid_d = 1'b1;
          req_addr_d  = FlushedAddr;
          req_w_d     = 1'b0;
          req_wdata_d = 32'h0000_0000;
          req_wstrb_d = WstrbNone;
        end else begin
          state_d = ST_WR_COMMIT;
        end
      end

      ST_POLL_RD: begin
        if (xfer_done_s) begin
          // Saturating so the counter cannot wrap even if MaxPolls is all-ones.
          if (poll_cnt_q == MaxPollsC) begin
            poll_cnt_d = poll_cnt_q;
          end else begin
            poll_cnt_d = poll_cnt_q + PollOneC;
          end
          req_valid_d = 1'b0;
          if (conf_resp_error_i) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else if (ways_flushed(conf_resp_rdata_i, mask_q)) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            done_err_d = 1'b0;
          end else if (poll_cnt_d == MaxPollsC) begin
            state_d    = ST_DONE;
            done_d     = 1'b1;
            done_err_d = 1'b1;
          end else begin
            state_d      = ST_POLL_WAIT;
            timer_load_s = 1'b1;
          end
        end else begin
          state_d = ST_POLL_RD;
        end
      end

      ST_POLL_WAIT: begin
        if (timer_expired_s) begin
          state_d     = ST_POLL_RD;
          req_valid_d = 1'b1;
          req_addr_d  = FlushedAddr;
          req_w_d     = 1'b0;
          req_wdata_d = 32'h0000_0000;
          req_wstrb_d = WstrbNone;
        end else begin
          state_d = ST_POLL_WAIT;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d     = ST_IDLE;
        req_valid_d = 1'b0;
      end
    endcase

    busy_d      = (state_d != ST_IDLE);
    cmd_ready_d = (state_d == ST_IDLE);
  end

  // State, command latches, poll counter and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      op_q        <= CFG_FLUSH;
      mask_q      <= 32'h0000_0000;
      poll_cnt_q  <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= 32'h0000_0000;
      req_w_q     <= 1'b0;
      req_wdata_q <= 32'h0000_0000;
      req_wstrb_q <= 4'h0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      busy_q      <= 1'b0;
      cmd_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      mask_q      <= mask_d;
      poll_cnt_q  <= poll_cnt_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      req_w_q     <= req_w_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      busy_q      <= busy_d;
      cmd_ready_q <= cmd_ready_d;
    end
  end

  assign cmd_ready_o      = cmd_ready_q;
  assign done_o           = done_q;
  assign done_error_o     = done_err_q;
  assign busy_o           = busy_q;
  assign conf_req_valid_o = req_valid_q;
  assign conf_req_addr_o  = req_addr_q;
  assign conf_req_w_o     = req_w_q;
  assign conf_req_wdata_o = req_wdata_q;
  assign conf_req_wstrb_o = req_wstrb_q;

endmodule
